// File: rtl/csa_tree_pipe_if.sv
// Handshake and data bundle between the partial-product generator, the CSA tree
// and the normalisation stage.
interface csa_tree_pipe_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 8
);
  localparam int OUT_W = WIDTH + $clog2(ROWS);

  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] rows_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      sum_o;
  logic [OUT_W-1:0]      carry_o;

  modport master (output in_valid, rows_i, out_ready,
                  input  in_ready, out_valid, sum_o, carry_o);
  modport slave  (input  in_valid, rows_i, out_ready,
                  output in_ready, out_valid, sum_o, carry_o);
endinterface

// File: rtl/csa_tree_pipe.sv
// Pipelined 5:3 / 3:2 carry-save reduction tree, one register stage per level,
// with an optional final carry-propagate stage.
module csa_tree_pipe #(
  parameter int WIDTH     = 16,
  parameter int ROWS      = 8,
  parameter int FINAL_ADD = 0
) (
  input  logic          clk,
  input  logic          rst,
  csa_tree_pipe_if.slave bus
);
  localparam int OUT_W = WIDTH + $clog2(ROWS);

  function automatic int next_rows(input int r);
    int rem;
    rem = r % 5;
    return (r / 5) * 3 + ((rem == 4) ? 3 : (rem == 3) ? 2 : rem);
  endfunction

  function automatic int rows_at(input int s);
    int r;
    r = ROWS;
    for (int i = 0; i < s; i++) r = next_rows(r);
    return r;
  endfunction

  function automatic int num_levels(input int rows);
    int r, n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = next_rows(r);
      n++;
    end
    return n;
  endfunction

  localparam int LEVELS = num_levels(ROWS);
  localparam int NST    = LEVELS + ((FINAL_ADD != 0) ? 1 : 0);

  typedef logic [ROWS-1:0][OUT_W-1:0] rows_t;

  // One reduction level on the first r rows; unused rows come out as zero.
  function automatic rows_t reduce_level(input rows_t x, input int r);
    rows_t      y;
    int         o, base, rem;
    logic [2:0] cnt;
    logic [OUT_W-1:0] a, b, c;
    y = '0;
    o = 0;
    for (int k = 0; k < ROWS / 5 + 1; k++) begin
      if (k < r / 5) begin
        for (int j = 0; j < OUT_W; j++) begin
          cnt = 3'(x[5*k][j]) + 3'(x[5*k+1][j]) + 3'(x[5*k+2][j]) +
                3'(x[5*k+3][j]) + 3'(x[5*k+4][j]);
          y[o][j] = cnt[0];
          if (j + 1 < OUT_W) y[o+1][j+1] = cnt[1];
          if (j + 2 < OUT_W) y[o+2][j+2] = cnt[2];
        end
        o = o + 3;
      end
    end
    base = 5 * (r / 5);
    rem  = r - base;
    if (rem >= 3) begin
      a = x[base];
      b = x[base+1];
      c = x[base+2];
      y[o]   = a ^ b ^ c;
      y[o+1] = ((a & b) | (a & c) | (b & c)) << 1;
      if (rem == 4) y[o+2] = x[base+3];
    end else if (rem >= 1) begin
      y[o] = x[base];
      if (rem == 2) y[o+1] = x[base+1];
    end
    return y;
  endfunction

  function automatic rows_t final_add(input rows_t x);
    rows_t y;
    y    = '0;
    y[0] = x[0] + x[1];
    return y;
  endfunction

  rows_t            rows_ext;
  rows_t            st_d [NST];
  rows_t            st_q [NST];
  logic [NST-1:0]   vld_q, adv, load;
  logic [NST:0]     rdy, src_v;

  always_comb begin
    rows_ext = '0;
    for (int k = 0; k < ROWS; k++) rows_ext[k] = OUT_W'(bus.rows_i[k*WIDTH +: WIDTH]);
  end

  for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
    if (s == 0) begin : g_first
      assign st_d[0] = reduce_level(rows_ext, ROWS);
    end else begin : g_next
      assign st_d[s] = reduce_level(st_q[s-1], rows_at(s));
    end
  end

  if (FINAL_ADD != 0) begin : g_fadd
    assign st_d[LEVELS] = final_add(st_q[LEVELS-1]);
  end

  // Ready ripples back from the consumer; each stage frees up in the cycle it advances.
  assign src_v = {vld_q, bus.in_valid};
  always_comb begin
    rdy      = '0;
    adv      = '0;
    load     = '0;
    rdy[NST] = bus.out_ready;
    for (int s = NST - 1; s >= 0; s--) begin
      adv[s]  = vld_q[s] & rdy[s+1];
      rdy[s]  = ~vld_q[s] | adv[s];
      load[s] = src_v[s] & rdy[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < NST; s++) st_q[s] <= '0;
    end else begin
      for (int s = 0; s < NST; s++) begin
        if (load[s]) begin
          vld_q[s] <= 1'b1;
          st_q[s]  <= st_d[s];
        end else if (adv[s]) begin
          vld_q[s] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_q[NST-1];
  assign bus.sum_o     = st_q[NST-1][0];
  assign bus.carry_o   = (FINAL_ADD != 0) ? '0 : st_q[NST-1][1];
endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined successor to the single-column 5:3 compressor.
- Reduces ROWS partial-product rows of WIDTH bits to a carry-save pair, or optionally to a single resolved sum.
- Each reduction level uses 5:3 compressors, plus 3:2 full adders for the remainder rows, with one register stage per level and a valid/ready handshake.
- Sits between the partial-product generator and the normalisation stage of the posit multiplier datapath.

Parameters:
- WIDTH, 16, bits per input row.
- ROWS, 8, number of input rows; legal range 3..32.
- FINAL_ADD, 0: 0 = output carry-save pair; 1 = extra stage adds the pair, sum_o valid and carry_o forced 0.
- OUT_W, WIDTH+$clog2(ROWS), output width. Localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  rows_i holds a valid operand set.
- in_ready  out  1  tree can accept rows_i this cycle.
- rows_i  in  ROWS*WIDTH  flattened rows; row k is bits [k*WIDTH +: WIDTH], unsigned.
- out_valid  out  1  sum_o/carry_o hold a result.
- out_ready  in  1  consumer accepts the result this cycle.
- sum_o  out  OUT_W  sum row, or resolved total when FINAL_ADD=1.
- carry_o  out  OUT_W  carry row, already weighted (shifted); 0 when FINAL_ADD=1.

Behaviour:
- Arithmetic contract: (sum_o + carry_o) mod 2^OUT_W equals the exact sum of all ROWS rows, zero-extended to OUT_W. The bit placement inside each row is implementation-defined; benches check only this contract.
- Level rule, r rows in:
  - floor(r/5) groups of 5 each go through 5:3 compressors per column (weights 1,2,4) and yield 3 rows.
  - Remainder 3 or 4: three rows go through a 3:2 full adder (2 rows out); any 4th row passes through.
  - Remainder 1 or 2: passes through.
  - Levels repeat until 2 rows remain.
- LEVELS by ROWS: 3→1, 4→2, 5→2, 8→3, 16→5. Generate this from a constant function.
- Latency: LEVELS cycles from an accepted input to out_valid, or LEVELS+1 when FINAL_ADD=1. No combinational path from rows_i to outputs.
- Each pipeline stage holds a valid bit v[s] and data.
  - Stage s loads when its input side presents valid data and (v[s]=0 or stage s advances this cycle).
  - Last stage advances when out_ready=1.
  - in_ready = ~v[0] | advance[0]. The ready chain is combinational back to in_ready; no skid buffer.
- Stall: with out_valid=1 and out_ready=0, sum_o/carry_o hold stable and the pipeline fills behind them. Once full, in_ready=0.
- Throughput: one result per cycle when out_ready is held high.
- Simultaneous accept and emit while full: in_ready=1 if out_ready=1 that cycle. No bubble, no loss.
- in_valid with in_ready=0: input is ignored and not captured. The source must hold it.
- Reset, asynchronous and effective immediately, including mid-operation:
  - All v[s]=0, out_valid=0, sum_o=0, carry_o=0.
  - In-flight data is discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- Width: carries out of bit OUT_W-1 are dropped. The maximum sum, ROWS*(2^WIDTH-1), always fits in OUT_W, so nothing is lost.
- No X on outputs after reset, even when a data register is loaded with an invalid stage.

Test Plan:
1. Defaults (ROWS=8, WIDTH=16). Send all rows 16'hFFFF with out_ready=1 → out_valid exactly 3 cycles after accept; sum_o+carry_o = 19'h7FFF8 (8×65535 = 524280).
2. Back-to-back: 20 random operand sets with out_ready=1 → 20 results, in order, on 20 consecutive cycles; each satisfies the arithmetic contract.
3. Backpressure: out_ready=0 for 6 cycles while streaming → in_ready drops after 3 accepted sets; outputs stay stable. Releasing out_ready drains in order with no duplicates or drops.
4. Assert rst mid-stream with 2 sets in flight → out_valid=0 and sum_o=carry_o=0 immediately; after release the first new set returns alone after 3 cycles.
5. FINAL_ADD=1, ROWS=5, WIDTH=8. Rows 1,2,3,4,5 → latency 3; sum_o=15, carry_o=0.
6. ROWS=3 edge case, WIDTH=4. Rows 4'hF,4'hF,4'h1 → latency 1; sum_o+carry_o=31, OUT_W=6.
